// File: rtl/cpu_pkg.sv
// Shared widths and owner encoding for the CPU memory arbiter.
package cpu_pkg;
  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 16;
  localparam int STREAK_W   = 4;

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_IF   = 2'd1;
  localparam logic [1:0] OWN_D    = 2'd2;

  // What the arbiter remembers about last cycle's grant.
  typedef struct packed {
    logic [1:0] owner;
    logic       rd;
  } rsp_t;
endpackage

// File: rtl/mem_arbiter_if.sv
// Fetch / data requester ports plus single-port memory bus of the arbiter.
interface mem_arbiter_if #(
  parameter int ADDR_W = cpu_pkg::ADDR_W_DEF,
  parameter int DATA_W = cpu_pkg::DATA_W_DEF
) ();
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_valid;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_valid;
  logic [DATA_W-1:0] rdata;
  logic              halt;
  logic              halted;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, halt, mem_rdata,
    output if_gnt, if_valid, d_gnt, d_valid, rdata, halted,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, halt, mem_rdata,
    input  if_gnt, if_valid, d_gnt, d_valid, rdata, halted,
           mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/arb_prio.sv
// Grant decision: data first, fetch forced through once the data streak saturates.
module arb_prio import cpu_pkg::*; #(
  parameter int MAX_STREAK = 4
) (
  input  logic                if_req,
  input  logic                d_req,
  input  logic                halt,
  input  logic [STREAK_W-1:0] streak,
  output logic                if_gnt,
  output logic                d_gnt
);
  localparam logic [STREAK_W-1:0] MAX_S = STREAK_W'(MAX_STREAK);

  logic if_win;

  always_comb begin
    if_win = if_req & ~halt & (~d_req | (streak == MAX_S));
    if_gnt = if_win;
    d_gnt  = d_req & ~if_win;
  end
endmodule

// File: rtl/mem_arbiter.sv
// Two-requester (fetch, load/store) arbiter onto a single-port synchronous memory.
module mem_arbiter import cpu_pkg::*; #(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int MAX_STREAK = 4
) (
  input  logic         clk,
  input  logic         reset,
  mem_arbiter_if.slave bus
);
  localparam logic [STREAK_W-1:0] MAX_S = STREAK_W'(MAX_STREAK);

  logic                if_gnt_raw, d_gnt_raw;
  logic                if_gnt, d_gnt;
  logic [STREAK_W-1:0] streak_q, streak_d;
  rsp_t                rsp_q, rsp_d;

  arb_prio #(.MAX_STREAK(MAX_STREAK)) u_prio (
    .if_req (bus.if_req),
    .d_req  (bus.d_req),
    .halt   (bus.halt),
    .streak (streak_q),
    .if_gnt (if_gnt_raw),
    .d_gnt  (d_gnt_raw)
  );

  // Grants are held off combinationally for the whole reset window.
  always_comb begin
    if_gnt        = if_gnt_raw & reset;
    d_gnt         = d_gnt_raw & reset;
    bus.if_gnt    = if_gnt;
    bus.d_gnt     = d_gnt;
    bus.mem_en    = if_gnt | d_gnt;
    bus.mem_we    = d_gnt & bus.d_we;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    if (if_gnt)     bus.mem_addr = bus.if_addr;
    else if (d_gnt) bus.mem_addr = bus.d_addr;
    if (d_gnt & bus.d_we) bus.mem_wdata = bus.d_wdata;
  end

  // Streak only counts data wins while fetch is actually waiting.
  always_comb begin
    streak_d = streak_q;
    if (if_gnt || !bus.if_req)
      streak_d = '0;
    else if (d_gnt && streak_q != MAX_S)
      streak_d = streak_q + STREAK_W'(1);
  end

  always_comb begin
    rsp_d.owner = OWN_NONE;
    if (if_gnt)     rsp_d.owner = OWN_IF;
    else if (d_gnt) rsp_d.owner = OWN_D;
    rsp_d.rd = if_gnt | (d_gnt & ~bus.d_we);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      streak_q <= '0;
      rsp_q    <= '0;
    end else begin
      streak_q <= streak_d;
      rsp_q    <= rsp_d;
    end
  end

  always_comb begin
    bus.if_valid = (rsp_q.owner == OWN_IF);
    bus.d_valid  = (rsp_q.owner == OWN_D);
    bus.rdata    = (rsp_q.owner != OWN_NONE && rsp_q.rd) ? bus.mem_rdata : '0;
    bus.halted   = bus.halt & (rsp_q.owner == OWN_NONE) & ~bus.d_req;
  end
endmodule
